// File: rtl/tlul_arb_2to1.sv
// Round-robin 2:1 TL-UL arbiter, one transaction outstanding, A beat registered toward the slave.
// Optional response timeout enabled with `define TLUL_ARB_TIMEOUT_EN.
module tlul_arb_2to1 #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int SW   = 2,
  parameter int TOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_h0_a_valid,
  output logic            o_h0_a_ready,
  input  logic [2:0]      i_h0_a_opcode,
  input  logic [AW-1:0]   i_h0_a_address,
  input  logic [DW/8-1:0] i_h0_a_mask,
  input  logic [DW-1:0]   i_h0_a_data,
  input  logic [SW-1:0]   i_h0_a_source,
  output logic            o_h0_d_valid,
  input  logic            i_h0_d_ready,
  output logic [2:0]      o_h0_d_opcode,
  output logic [DW-1:0]   o_h0_d_data,
  output logic [SW-1:0]   o_h0_d_source,
  output logic            o_h0_d_error,
  input  logic            i_h1_a_valid,
  output logic            o_h1_a_ready,
  input  logic [2:0]      i_h1_a_opcode,
  input  logic [AW-1:0]   i_h1_a_address,
  input  logic [DW/8-1:0] i_h1_a_mask,
  input  logic [DW-1:0]   i_h1_a_data,
  input  logic [SW-1:0]   i_h1_a_source,
  output logic            o_h1_d_valid,
  input  logic            i_h1_d_ready,
  output logic [2:0]      o_h1_d_opcode,
  output logic [DW-1:0]   o_h1_d_data,
  output logic [SW-1:0]   o_h1_d_source,
  output logic            o_h1_d_error,
  output logic            o_s_a_valid,
  input  logic            i_s_a_ready,
  output logic [2:0]      o_s_a_opcode,
  output logic [AW-1:0]   o_s_a_address,
  output logic [DW/8-1:0] o_s_a_mask,
  output logic [DW-1:0]   o_s_a_data,
  output logic [SW-1:0]   o_s_a_source,
  input  logic            i_s_d_valid,
  output logic            o_s_d_ready,
  input  logic [2:0]      i_s_d_opcode,
  input  logic [DW-1:0]   i_s_d_data,
  input  logic [SW-1:0]   i_s_d_source,
  input  logic            i_s_d_error
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            r_state;
  logic              r_ptr;
  logic              r_owner;
  logic [2:0]        r_opcode;
  logic [AW-1:0]     r_address;
  logic [DW/8-1:0]   r_mask;
  logic [DW-1:0]     r_data;
  logic [SW-1:0]     r_source;

  logic w_any_req;
  logic w_grant;
  logic w_a_hs;
  logic w_in_resp;
  logic w_owner_d_ready;
  logic w_tpend;
  logic w_d_valid;
  logic w_d_done;

  // Pointer host wins a tie; a lone requester wins regardless of the pointer.
  assign w_any_req = i_h0_a_valid | i_h1_a_valid;
  assign w_grant   = r_ptr ? i_h1_a_valid : ~i_h0_a_valid;
  assign w_a_hs    = i_reset_n && (r_state == IDLE) && w_any_req;

  assign o_h0_a_ready = w_a_hs && !w_grant;
  assign o_h1_a_ready = w_a_hs &&  w_grant;

  assign w_in_resp       = (r_state == RESP);
  assign w_owner_d_ready = r_owner ? i_h1_d_ready : i_h0_d_ready;
  assign w_d_valid       = w_in_resp && (w_tpend || i_s_d_valid);
  assign w_d_done        = w_d_valid && w_owner_d_ready;

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TOUT - 1);
  logic [7:0] r_tcnt;
  logic       r_tpend;

  // The counter only advances while the slave is silent; a pending timeout freezes it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_tcnt  <= '0;
      r_tpend <= 1'b0;
    end else if (r_state == REQ && i_s_a_ready) begin
      r_tcnt  <= '0;
      r_tpend <= 1'b0;
    end else if (w_in_resp && !r_tpend && !i_s_d_valid) begin
      if (r_tcnt == TLIM) r_tpend <= 1'b1;
      else                r_tcnt  <= r_tcnt + 8'd1;
    end else if (w_in_resp && r_tpend && w_owner_d_ready) begin
      r_tpend <= 1'b0;
    end
  end

  assign w_tpend = r_tpend;
`else
  assign w_tpend = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_opcode  <= '0;
      r_address <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      r_source  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_a_hs) begin
          r_opcode  <= w_grant ? i_h1_a_opcode  : i_h0_a_opcode;
          r_address <= w_grant ? i_h1_a_address : i_h0_a_address;
          r_mask    <= w_grant ? i_h1_a_mask    : i_h0_a_mask;
          r_data    <= w_grant ? i_h1_a_data    : i_h0_a_data;
          r_source  <= w_grant ? i_h1_a_source  : i_h0_a_source;
          r_owner   <= w_grant;
          r_ptr     <= ~w_grant;
          r_state   <= REQ;
        end
        REQ:  if (i_s_a_ready) r_state <= RESP;
        RESP: if (w_d_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_s_a_valid   = (r_state == REQ);
  assign o_s_a_opcode  = r_opcode;
  assign o_s_a_address = r_address;
  assign o_s_a_mask    = r_mask;
  assign o_s_a_data    = r_data;
  assign o_s_a_source  = r_source;

  // IDLE sinks stray slave beats; RESP forwards the owner's ready unless a timeout is pending.
  assign o_s_d_ready = i_reset_n &&
                       ((r_state == IDLE) || (w_in_resp && !w_tpend && w_owner_d_ready));

  assign o_h0_d_valid  = w_d_valid && !r_owner;
  assign o_h1_d_valid  = w_d_valid &&  r_owner;
  assign o_h0_d_opcode = w_tpend ? {2'b00, r_opcode == 3'd4} : i_s_d_opcode;
  assign o_h1_d_opcode = o_h0_d_opcode;
  assign o_h0_d_data   = w_tpend ? '0 : i_s_d_data;
  assign o_h1_d_data   = o_h0_d_data;
  assign o_h0_d_source = w_tpend ? r_source : i_s_d_source;
  assign o_h1_d_source = o_h0_d_source;
  assign o_h0_d_error  = w_tpend | i_s_d_error;
  assign o_h1_d_error  = o_h0_d_error;

endmodule

// File: tb/tb_tlul_arb_2to1.sv
// Directed bench for tlul_arb_2to1; the timeout check is built only with TLUL_ARB_TIMEOUT_EN.
module tb_tlul_arb_2to1;
  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_h0_a_valid, i_h1_a_valid;
  logic        o_h0_a_ready, o_h1_a_ready;
  logic [2:0]  i_h0_a_opcode, i_h1_a_opcode;
  logic [31:0] i_h0_a_address, i_h1_a_address;
  logic [3:0]  i_h0_a_mask, i_h1_a_mask;
  logic [31:0] i_h0_a_data, i_h1_a_data;
  logic [1:0]  i_h0_a_source, i_h1_a_source;
  logic        o_h0_d_valid, o_h1_d_valid;
  logic        i_h0_d_ready, i_h1_d_ready;
  logic [2:0]  o_h0_d_opcode, o_h1_d_opcode;
  logic [31:0] o_h0_d_data, o_h1_d_data;
  logic [1:0]  o_h0_d_source, o_h1_d_source;
  logic        o_h0_d_error, o_h1_d_error;
  logic        o_s_a_valid, i_s_a_ready;
  logic [2:0]  o_s_a_opcode;
  logic [31:0] o_s_a_address;
  logic [3:0]  o_s_a_mask;
  logic [31:0] o_s_a_data;
  logic [1:0]  o_s_a_source;
  logic        i_s_d_valid, o_s_d_ready;
  logic [2:0]  i_s_d_opcode;
  logic [31:0] i_s_d_data;
  logic [1:0]  i_s_d_source;
  logic        i_s_d_error;

  int assertCount = 0;
  int failCount   = 0;

  tlul_arb_2to1 #(.AW(32), .DW(32), .SW(2), .TOUT(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_h0_a_valid(i_h0_a_valid), .o_h0_a_ready(o_h0_a_ready), .i_h0_a_opcode(i_h0_a_opcode),
    .i_h0_a_address(i_h0_a_address), .i_h0_a_mask(i_h0_a_mask), .i_h0_a_data(i_h0_a_data),
    .i_h0_a_source(i_h0_a_source), .o_h0_d_valid(o_h0_d_valid), .i_h0_d_ready(i_h0_d_ready),
    .o_h0_d_opcode(o_h0_d_opcode), .o_h0_d_data(o_h0_d_data), .o_h0_d_source(o_h0_d_source),
    .o_h0_d_error(o_h0_d_error),
    .i_h1_a_valid(i_h1_a_valid), .o_h1_a_ready(o_h1_a_ready), .i_h1_a_opcode(i_h1_a_opcode),
    .i_h1_a_address(i_h1_a_address), .i_h1_a_mask(i_h1_a_mask), .i_h1_a_data(i_h1_a_data),
    .i_h1_a_source(i_h1_a_source), .o_h1_d_valid(o_h1_d_valid), .i_h1_d_ready(i_h1_d_ready),
    .o_h1_d_opcode(o_h1_d_opcode), .o_h1_d_data(o_h1_d_data), .o_h1_d_source(o_h1_d_source),
    .o_h1_d_error(o_h1_d_error),
    .o_s_a_valid(o_s_a_valid), .i_s_a_ready(i_s_a_ready), .o_s_a_opcode(o_s_a_opcode),
    .o_s_a_address(o_s_a_address), .o_s_a_mask(o_s_a_mask), .o_s_a_data(o_s_a_data),
    .o_s_a_source(o_s_a_source), .i_s_d_valid(i_s_d_valid), .o_s_d_ready(o_s_d_ready),
    .i_s_d_opcode(i_s_d_opcode), .i_s_d_data(i_s_d_data), .i_s_d_source(i_s_d_source),
    .i_s_d_error(i_s_d_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic applyStimulus(input int host, input logic valid, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, input logic [1:0] src);
    if (host == 0) begin
      i_h0_a_valid = valid; i_h0_a_opcode = op; i_h0_a_address = addr;
      i_h0_a_data = data; i_h0_a_mask = mask; i_h0_a_source = src;
    end else begin
      i_h1_a_valid = valid; i_h1_a_opcode = op; i_h1_a_address = addr;
      i_h1_a_data = data; i_h1_a_mask = mask; i_h1_a_source = src;
    end
  endtask

  // Called in an IDLE cycle with host requests already driven; returns in the following IDLE cycle.
  task automatic runTxn(input int expHost, input logic [2:0] expOp, input logic [31:0] expAddr,
                        input logic [31:0] expData, input logic [3:0] expMask, input logic [1:0] expSrc,
                        input int aStall, input int dHold, input logic [31:0] rdata);
    logic [2:0] respOp;
    respOp = (expOp == 3'd4) ? 3'd1 : 3'd0;
    #1;
    checkOutput("grant_h0", o_h0_a_ready, expHost == 0);
    checkOutput("grant_h1", o_h1_a_ready, expHost == 1);
    checkOutput("idle_s_a_valid", o_s_a_valid, 0);
    step();
    for (int i = 0; i <= aStall; i++) begin
      i_s_a_ready = (i == aStall);
      #1;
      checkOutput("req_s_a_valid", o_s_a_valid, 1);
      checkOutput("req_opcode", o_s_a_opcode, expOp);
      checkOutput("req_address", o_s_a_address, expAddr);
      checkOutput("req_data", o_s_a_data, expData);
      checkOutput("req_mask", o_s_a_mask, expMask);
      checkOutput("req_source", o_s_a_source, expSrc);
      checkOutput("req_ready_h0", o_h0_a_ready, 0);
      checkOutput("req_ready_h1", o_h1_a_ready, 0);
      step();
    end
    i_s_a_ready = 1'b0;
    i_s_d_valid = 1'b1; i_s_d_opcode = respOp; i_s_d_data = rdata;
    i_s_d_source = expSrc; i_s_d_error = 1'b0;
    for (int i = 0; i <= dHold; i++) begin
      if (expHost == 0) i_h0_d_ready = (i == dHold);
      else              i_h1_d_ready = (i == dHold);
      #1;
      checkOutput("resp_s_d_ready", o_s_d_ready, i == dHold);
      checkOutput("resp_h0_d_valid", o_h0_d_valid, expHost == 0);
      checkOutput("resp_h1_d_valid", o_h1_d_valid, expHost == 1);
      checkOutput("resp_data", expHost == 0 ? o_h0_d_data : o_h1_d_data, rdata);
      checkOutput("resp_source", expHost == 0 ? o_h0_d_source : o_h1_d_source, expSrc);
      checkOutput("resp_opcode", expHost == 0 ? o_h0_d_opcode : o_h1_d_opcode, respOp);
      checkOutput("resp_error", expHost == 0 ? o_h0_d_error : o_h1_d_error, 0);
      step();
    end
    i_s_d_valid = 1'b0;
  endtask

  initial begin
    int n;
    i_reset_n = 1'b0;
    i_s_a_ready = 1'b0; i_s_d_valid = 1'b0; i_s_d_opcode = '0; i_s_d_data = '0;
    i_s_d_source = '0; i_s_d_error = 1'b0;
    i_h0_d_ready = 1'b1; i_h1_d_ready = 1'b1;
    applyStimulus(0, 1'b1, 3'd4, 32'h0, 32'h0, 4'hF, 2'd0);
    applyStimulus(1, 1'b1, 3'd4, 32'h0, 32'h0, 4'hF, 2'd0);
    repeat (2) @(posedge i_clk);
    step(); #1;
    checkOutput("rst_h0_a_ready", o_h0_a_ready, 0);
    checkOutput("rst_h1_a_ready", o_h1_a_ready, 0);
    checkOutput("rst_s_a_valid", o_s_a_valid, 0);
    checkOutput("rst_s_d_ready", o_s_d_ready, 0);
    checkOutput("rst_h0_d_valid", o_h0_d_valid, 0);
    checkOutput("rst_h1_d_valid", o_h1_d_valid, 0);
    i_reset_n = 1'b1;
    i_h0_a_valid = 1'b0; i_h1_a_valid = 1'b0;
    step();

    $display("[TB] h0-only PutFull");
    applyStimulus(0, 1'b1, 3'd0, 32'h0, 32'hA5, 4'h1, 2'd2);
    #1;
    checkOutput("idle_s_d_ready", o_s_d_ready, 1);
    fork
      runTxn(0, 3'd0, 32'h0, 32'hA5, 4'h1, 2'd2, 0, 0, 32'h0);
      begin step(); i_h0_a_valid = 1'b0; end
    join
    #1;
    checkOutput("post_put_h0_d_valid", o_h0_d_valid, 0);
    checkOutput("post_put_h1_d_valid", o_h1_d_valid, 0);

    $display("[TB] both hosts Get after reset");
    i_reset_n = 1'b0;
    step(); step();
    i_reset_n = 1'b1;
    applyStimulus(0, 1'b1, 3'd4, 32'h10, 32'h0, 4'hF, 2'd1);
    applyStimulus(1, 1'b1, 3'd4, 32'h20, 32'h0, 4'hF, 2'd3);
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) runTxn(0, 3'd4, 32'h10, 32'h0, 4'hF, 2'd1, 0, 0, 32'h1000 + t);
      else            runTxn(1, 3'd4, 32'h20, 32'h0, 4'hF, 2'd3, 0, 0, 32'h2000 + t);
    end

    $display("[TB] slave A stall, then h1 D-ready hold");
    runTxn(0, 3'd4, 32'h10, 32'h0, 4'hF, 2'd1, 5, 0, 32'hCAFE0000);
    i_h0_a_valid = 1'b0;
    runTxn(1, 3'd4, 32'h20, 32'h0, 4'hF, 2'd3, 0, 3, 32'hBEEF1234);
    #1;
    checkOutput("hold_idle_s_d_ready", o_s_d_ready, 1);
    checkOutput("hold_idle_h1_d_valid", o_h1_d_valid, 0);
    checkOutput("hold_idle_s_a_valid", o_s_a_valid, 0);

    $display("[TB] single requester back-to-back");
    applyStimulus(1, 1'b1, 3'd1, 32'h44, 32'h12345678, 4'h3, 2'd0);
    runTxn(1, 3'd1, 32'h44, 32'h12345678, 4'h3, 2'd0, 0, 0, 32'h0);
    runTxn(1, 3'd1, 32'h44, 32'h12345678, 4'h3, 2'd0, 1, 1, 32'h0);
    i_h1_a_valid = 1'b0;

    $display("[TB] reset mid-transaction");
    applyStimulus(0, 1'b1, 3'd4, 32'h80, 32'h0, 4'hF, 2'd2);
    step();
    i_h0_a_valid = 1'b0;
    #1;
    checkOutput("mid_s_a_valid", o_s_a_valid, 1);
    i_reset_n = 1'b0;
    step(); step();
    #1;
    checkOutput("mid_rst_s_a_valid", o_s_a_valid, 0);
    i_reset_n = 1'b1;
    i_s_d_valid = 1'b1; i_s_d_data = 32'hDEAD;
    #1;
    checkOutput("stray_s_d_ready", o_s_d_ready, 1);
    checkOutput("stray_h0_d_valid", o_h0_d_valid, 0);
    step();
    i_s_d_valid = 1'b0;

`ifdef TLUL_ARB_TIMEOUT_EN
    $display("[TB] response timeout");
    applyStimulus(0, 1'b1, 3'd4, 32'h90, 32'h0, 4'hF, 2'd3);
    step();
    i_h0_a_valid = 1'b0;
    i_s_a_ready = 1'b1;
    step();
    i_s_a_ready = 1'b0;
    n = 0;
    #1;
    while (!o_h0_d_valid && n < 40) begin
      step(); #1;
      n++;
    end
    checkOutput("tout_latency", n, 16);
    checkOutput("tout_error", o_h0_d_error, 1);
    checkOutput("tout_opcode", o_h0_d_opcode, 1);
    checkOutput("tout_data", o_h0_d_data, 0);
    checkOutput("tout_source", o_h0_d_source, 3);
    checkOutput("tout_s_d_ready", o_s_d_ready, 0);
    step(); #1;
    checkOutput("tout_done", o_h0_d_valid, 0);
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
